priv_1_12_trap_sequencer: RTL and testbench
===========================================

// Module: priv_1_12_trap_sequencer
// PURPOSE
//  Machine-mode trap sequencer inside the v1.12 privilege block. It is the initiator that
//  drives the CSR file's inject/next_* write port and the pipeline's redirect port.
//  It arbitrates exceptions and interrupts, waits for the pipeline to drain, commits trap
//  CSR updates (or mret restore), redirects the PC, and owns the current privilege level.
//  No delegation: every trap is taken to M-mode.
// PARAMETERS
//  RESET_PRIV     2'b11     privilege level after reset (M)
//  VEC_SHIFT      2         vectored-mode offset = cause_code << VEC_SHIFT
// PORTS
//  CLK                   in   1   clock
//  nRST                  in   1   synchronous active-low reset
//  ex_src                in   16  exception requests, bit index = mcause exception code
//  ex_tval               in   32  trap value accompanying the exception
//  epc                   in   32  pc of the faulting/interrupted instruction
//  mret                  in   1   mret retiring
//  pipe_clear            in   1   pipeline drained of hazards
//  curr_mip, curr_mie    in   32  CSR file pending/enable
//  curr_mstatus          in   32  MIE[3], MPIE[7], MPP[12:11]
//  curr_mtvec            in   32  BASE[31:2], MODE[1:0] (0 = direct, 1 = vectored)
//  curr_mepc             in   32  return target for mret
//  intr                  out  1   trap/mret sequence in progress (pipe stalls fetch)
//  inject_mcause, inject_mepc, inject_mtval, inject_mstatus  out  1  CSR write strobes
//  next_mcause, next_mepc, next_mtval, next_mstatus          out  32 CSR write data
//  insert_pc             out  1   one-cycle pipeline redirect
//  priv_pc               out  32  redirect target
//  curr_privilege_level  out  2   current privilege
// BEHAVIOUR
//  Reset (nRST = 0 at posedge): state = IDLE, curr_privilege_level = RESET_PRIV; all strobes,
//  intr, and insert_pc = 0; next_* and priv_pc = 0. Reset mid-sequence aborts it with no CSR write.
//  Interrupt enable: gie = (priv != M) | mstatus.MIE; pend = curr_mip & curr_mie & {32{gie}}.
//  Interrupt priority: 11 > 3 > 7 > 9 > 1 > 5. Other pend bits are ignored.
//  Exception priority: 3 > 12 > 1 > 2 > 0 > 8/9/11 > 6 > 4 > 15 > 13 > 7 > 5.
//  Exceptions beat interrupts. Any trap beats mret.
//  States:
//   IDLE: trap pending -> latch cause/epc/tval (tval = 0 for interrupts) -> WAIT_TRAP.
//         Else if mret -> WAIT_MRET. intr = 0.
//   WAIT_TRAP: intr = 1. Hold until pipe_clear = 1 -> TRAP_WR. New ex_src, interrupts, and
//         mret are ignored. Cause stays latched even if the source deasserts.
//   TRAP_WR (1 cycle): all four inject_* = 1.
//         next_mcause = {is_int, 27'b0, code}; next_mepc = {epc[31:2], 2'b00};
//         next_mtval = latched tval.
//         next_mstatus = mstatus with MPIE <- MIE, MIE <- 0, MPP <- priv.
//         Target priv = M. -> REDIRECT.
//   WAIT_MRET: intr = 1. On pipe_clear -> MRET_WR.
//   MRET_WR (1 cycle): inject_mstatus only.
//         next_mstatus: MIE <- MPIE, MPIE <- 1, MPP <- 2'b00.
//         Target priv = old MPP (2'b10 is treated as 2'b00). -> REDIRECT.
//   REDIRECT (1 cycle): insert_pc = 1, curr_privilege_level <- target on this edge.
//         Trap: priv_pc = {BASE, 2'b00}, plus (code << VEC_SHIFT) if MODE == 1 and is_int.
//         mret: priv_pc = {curr_mepc[31:2], 2'b00}. intr = 1. -> IDLE.
//  Latency with pipe_clear already high: request -> inject at +2 cycles, insert_pc at +3.
//  Back-to-back: a new trap can be accepted in the IDLE cycle right after REDIRECT.
//  MODE >= 2 is treated as direct.
// TESTING
//  Reset: hold nRST = 0 for 2 cycles -> priv = 2'b11; intr, insert_pc, inject_* = 0.
//  ex_src[2], epc = 0x100, pipe_clear = 0 for 3 cycles then 1, mtvec = 0x8000_0000
//   -> inject: mcause = 0x2, mepc = 0x100; next cycle insert_pc = 1, priv_pc = 0x8000_0000.
//  mip[7] = mie[7] = 1, MIE = 1, mtvec = 0x8000_0001
//   -> mcause = 0x8000_0007, priv_pc = 0x8000_001C, next_mstatus.MIE = 0, MPIE = 1.
//  ex_src[3] and ex_src[2] plus mip/mie[11] in the same cycle
//   -> mcause = 0x3; the interrupt is taken on a later pass.
//  From U-mode with MIE = 0, mip/mie[3] = 1 -> trap taken, mcause = 0x8000_0003,
//   MPP = 0, priv -> 3. Then mret with mepc = 0x200 -> priv_pc = 0x200, priv = 0, MIE = 1.
//  nRST = 0 during WAIT_TRAP -> no inject_* pulse, state IDLE, priv = 3.

Source files
------------

// File: rtl/priv_1_12_trap_sequencer.sv
// ---------------------------------------------------------------------------
// priv_1_12_trap_sequencer
//
// Machine-mode trap sequencer for the v1.12 privilege block. It picks the
// highest-priority exception or interrupt, or accepts an mret. It then waits
// for the pipeline to drain and writes the trap CSRs (or restores mstatus for
// mret) through the CSR file's inject/next_* port. After that it redirects the
// PC and updates the current privilege level. No delegation is supported, so
// every trap lands in M-mode.
//
// Ports
//   CLK, nRST                 clock, synchronous active-low reset
//   ex_src[15:0]              exception requests, bit index = exception code
//   ex_tval, epc              trap value / pc of faulting instruction
//   mret                      mret retiring
//   pipe_clear                pipeline has drained
//   curr_mip, curr_mie        pending / enabled interrupts from the CSR file
//   curr_mstatus              MIE[3], MPIE[7], MPP[12:11]
//   curr_mtvec, curr_mepc     trap vector base/mode, mret return address
//   intr                      sequence in progress (fetch stalls)
//   inject_* / next_*         CSR write strobes and write data
//   insert_pc, priv_pc        one-cycle pipeline redirect and its target
//   curr_privilege_level      current privilege level
// ---------------------------------------------------------------------------
module priv_1_12_trap_sequencer #(
  parameter logic [1:0] RESET_PRIV = 2'b11,
  parameter int         VEC_SHIFT  = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [15:0] ex_src,
  input  logic [31:0] ex_tval,
  input  logic [31:0] epc,
  input  logic        mret,
  input  logic        pipe_clear,
  input  logic [31:0] curr_mip,
  input  logic [31:0] curr_mie,
  input  logic [31:0] curr_mstatus,
  input  logic [31:0] curr_mtvec,
  input  logic [31:0] curr_mepc,
  output logic        intr,
  output logic        inject_mcause,
  output logic        inject_mepc,
  output logic        inject_mtval,
  output logic        inject_mstatus,
  output logic [31:0] next_mcause,
  output logic [31:0] next_mepc,
  output logic [31:0] next_mtval,
  output logic [31:0] next_mstatus,
  output logic        insert_pc,
  output logic [31:0] priv_pc,
  output logic [1:0]  curr_privilege_level
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TRAP,
    TRAP_WR,
    WAIT_MRET,
    MRET_WR,
    REDIRECT
  } state_t;

  // Priority tables, highest priority first. Exceptions 8/9/11 are mutually
  // exclusive, so their relative order does not matter.
  localparam int EX_N  = 14;
  localparam int INT_N = 6;
  localparam logic [3:0] EX_PRIO [0:EX_N-1] = '{
    4'd3, 4'd12, 4'd1, 4'd2, 4'd0, 4'd8, 4'd9, 4'd11,
    4'd6, 4'd4, 4'd15, 4'd13, 4'd7, 4'd5
  };
  localparam logic [3:0] INT_PRIO [0:INT_N-1] = '{
    4'd11, 4'd3, 4'd7, 4'd9, 4'd1, 4'd5
  };

  state_t      state_reg;
  logic        is_int_reg;
  logic [3:0]  code_reg;
  logic [29:0] epc_reg;
  logic [31:0] tval_reg;
  logic [1:0]  target_priv_reg;

  logic        gie;
  logic [31:0] pend;
  logic        ex_valid;
  logic [3:0]  ex_code;
  logic        int_valid;
  logic [3:0]  int_code;
  logic [31:0] vec_offset;

  // The low bits of the pc inputs are forced to zero on their way out.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{epc[1:0], curr_mepc[1:0]};

  // The loops run from lowest to highest priority, so the last match
  // (the highest priority) is the one that sticks.
  always_comb begin
    gie       = (curr_privilege_level != 2'b11) | curr_mstatus[3];
    pend      = curr_mip & curr_mie & {32{gie}};
    ex_valid  = 1'b0;
    ex_code   = 4'd0;
    int_valid = 1'b0;
    int_code  = 4'd0;
    for (int i = EX_N - 1; i >= 0; i--) begin
      if (ex_src[EX_PRIO[i]]) begin
        ex_valid = 1'b1;
        ex_code  = EX_PRIO[i];
      end
    end
    for (int i = INT_N - 1; i >= 0; i--) begin
      if (pend[{1'b0, INT_PRIO[i]}]) begin
        int_valid = 1'b1;
        int_code  = INT_PRIO[i];
      end
    end
  end

  // The vectored offset applies only to interrupts in mode 1. Modes 2 and 3
  // fall back to direct mode.
  assign vec_offset = (curr_mtvec[1:0] == 2'b01 && is_int_reg)
                      ? ({28'd0, code_reg} << VEC_SHIFT) : 32'd0;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_reg            <= IDLE;
      curr_privilege_level <= RESET_PRIV;
      is_int_reg           <= 1'b0;
      code_reg             <= 4'd0;
      epc_reg              <= 30'd0;
      tval_reg             <= 32'd0;
      target_priv_reg      <= RESET_PRIV;
      intr                 <= 1'b0;
      inject_mcause        <= 1'b0;
      inject_mepc          <= 1'b0;
      inject_mtval         <= 1'b0;
      inject_mstatus       <= 1'b0;
      next_mcause          <= 32'd0;
      next_mepc            <= 32'd0;
      next_mtval           <= 32'd0;
      next_mstatus         <= 32'd0;
      insert_pc            <= 1'b0;
      priv_pc              <= 32'd0;
    end else begin
      // Write strobes and the redirect last one cycle only.
      inject_mcause  <= 1'b0;
      inject_mepc    <= 1'b0;
      inject_mtval   <= 1'b0;
      inject_mstatus <= 1'b0;
      insert_pc      <= 1'b0;

      case (state_reg)
        IDLE: begin
          // Exceptions beat interrupts, and any trap beats mret.
          if (ex_valid || int_valid) begin
            is_int_reg <= !ex_valid;
            code_reg   <= ex_valid ? ex_code : int_code;
            epc_reg    <= epc[31:2];
            tval_reg   <= ex_valid ? ex_tval : 32'd0;
            intr       <= 1'b1;
            state_reg  <= WAIT_TRAP;
          end else if (mret) begin
            intr      <= 1'b1;
            state_reg <= WAIT_MRET;
          end else begin
            intr <= 1'b0;
          end
        end

        WAIT_TRAP: begin
          if (pipe_clear) begin
            inject_mcause   <= 1'b1;
            inject_mepc     <= 1'b1;
            inject_mtval    <= 1'b1;
            inject_mstatus  <= 1'b1;
            next_mcause     <= {is_int_reg, 27'd0, code_reg};
            next_mepc       <= {epc_reg, 2'b00};
            next_mtval      <= tval_reg;
            next_mstatus    <= {curr_mstatus[31:13], curr_privilege_level,
                                curr_mstatus[10:8], curr_mstatus[3],
                                curr_mstatus[6:4], 1'b0, curr_mstatus[2:0]};
            target_priv_reg <= 2'b11;
            state_reg       <= TRAP_WR;
          end
        end

        TRAP_WR: begin
          insert_pc <= 1'b1;
          priv_pc   <= {curr_mtvec[31:2], 2'b00} + vec_offset;
          state_reg <= REDIRECT;
        end

        WAIT_MRET: begin
          if (pipe_clear) begin
            inject_mstatus  <= 1'b1;
            next_mstatus    <= {curr_mstatus[31:13], 2'b00,
                                curr_mstatus[10:8], 1'b1,
                                curr_mstatus[6:4], curr_mstatus[7],
                                curr_mstatus[2:0]};
            // Hypervisor encoding is unsupported, so MPP = 2'b10 returns to U.
            target_priv_reg <= (curr_mstatus[12:11] == 2'b10)
                               ? 2'b00 : curr_mstatus[12:11];
            state_reg       <= MRET_WR;
          end
        end

        MRET_WR: begin
          insert_pc <= 1'b1;
          priv_pc   <= {curr_mepc[31:2], 2'b00};
          state_reg <= REDIRECT;
        end

        REDIRECT: begin
          curr_privilege_level <= target_priv_reg;
          intr                 <= 1'b0;
          state_reg            <= IDLE;
        end

        default: begin
          intr      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_priv_1_12_trap_sequencer.sv
// ---------------------------------------------------------------------------
// tb_priv_1_12_trap_sequencer
//
// Directed bench for the trap sequencer. A transaction-level reference model
// records each accepted trap or mret. It notes the edge at which the pipeline
// drained and derives every output from that. The CSR write is expected in the
// cycle after the drain edge, and the redirect in the cycle after that.
// Literal expectations in the stimulus pin the model to hand-worked values.
// ---------------------------------------------------------------------------
module tb_priv_1_12_trap_sequencer;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [15:0] ex_src;
  logic [31:0] ex_tval, epc;
  logic        mret, pipe_clear;
  logic [31:0] curr_mip, curr_mie, curr_mstatus, curr_mtvec, curr_mepc;
  logic        intr, inject_mcause, inject_mepc, inject_mtval, inject_mstatus;
  logic [31:0] next_mcause, next_mepc, next_mtval, next_mstatus;
  logic        insert_pc;
  logic [31:0] priv_pc;
  logic [1:0]  curr_privilege_level;

  priv_1_12_trap_sequencer dut (
    .CLK(CLK), .nRST(nRST), .ex_src(ex_src), .ex_tval(ex_tval), .epc(epc),
    .mret(mret), .pipe_clear(pipe_clear), .curr_mip(curr_mip),
    .curr_mie(curr_mie), .curr_mstatus(curr_mstatus),
    .curr_mtvec(curr_mtvec), .curr_mepc(curr_mepc), .intr(intr),
    .inject_mcause(inject_mcause), .inject_mepc(inject_mepc),
    .inject_mtval(inject_mtval), .inject_mstatus(inject_mstatus),
    .next_mcause(next_mcause), .next_mepc(next_mepc),
    .next_mtval(next_mtval), .next_mstatus(next_mstatus),
    .insert_pc(insert_pc), .priv_pc(priv_pc),
    .curr_privilege_level(curr_privilege_level)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int ex_order  [14] = '{3, 12, 1, 2, 0, 8, 9, 11, 6, 4, 15, 13, 7, 5};
  int int_order [6]  = '{11, 3, 7, 9, 1, 5};

  int          m_cyc = 0;
  int          m_clear_cyc = 0;
  int          m_code = 0;
  bit          m_ready = 0, m_rst = 0, m_active = 0, m_cleared = 0;
  bit          m_is_int = 0, m_is_mret = 0;
  logic [1:0]  m_priv = 2'b11, m_target = 2'b11;
  logic [31:0] m_epc = 0, m_tval = 0;
  logic [31:0] e_mcause = 0, e_mepc = 0, e_mtval = 0, e_mstatus = 0, e_pc = 0;
  bit          e_write = 0, e_redir = 0;

  task automatic model_step();
    bit found;
    bit gie;
    logic [31:0] ms;
    m_cyc++;
    if (!nRST) begin
      m_ready = 1; m_rst = 1; m_active = 0; m_cleared = 0; m_priv = 2'b11;
    end else begin
      m_rst = 0;
      if (!m_active) begin
        found = 0;
        for (int k = 0; k < 14; k++)
          if (!found && ex_src[ex_order[k]]) begin
            found = 1; m_is_int = 0; m_code = ex_order[k];
          end
        gie = (m_priv != 2'b11) || curr_mstatus[3];
        for (int k = 0; k < 6; k++)
          if (!found && gie && curr_mip[int_order[k]] && curr_mie[int_order[k]]) begin
            found = 1; m_is_int = 1; m_code = int_order[k];
          end
        if (found) begin
          m_active = 1; m_is_mret = 0; m_cleared = 0;
          m_epc = epc; m_tval = m_is_int ? 32'd0 : ex_tval;
        end else if (mret) begin
          m_active = 1; m_is_mret = 1; m_cleared = 0;
        end
      end else if (!m_cleared) begin
        if (pipe_clear) begin
          m_cleared = 1; m_clear_cyc = m_cyc;
          ms = curr_mstatus;
          if (m_is_mret) begin
            ms[3] = curr_mstatus[7]; ms[7] = 1'b1; ms[12:11] = 2'b00;
            m_target = (curr_mstatus[12:11] == 2'b10) ? 2'b00 : curr_mstatus[12:11];
          end else begin
            ms[7] = curr_mstatus[3]; ms[3] = 1'b0; ms[12:11] = m_priv;
            m_target = 2'b11;
            e_mcause = (m_is_int ? 32'h8000_0000 : 32'h0) | m_code;
            e_mepc   = m_epc & 32'hFFFF_FFFC;
            e_mtval  = m_tval;
          end
          e_mstatus = ms;
        end
      end else if (m_cyc == m_clear_cyc + 1) begin
        if (m_is_mret) e_pc = curr_mepc & 32'hFFFF_FFFC;
        else begin
          e_pc = curr_mtvec & 32'hFFFF_FFFC;
          if (curr_mtvec[1:0] == 2'b01 && m_is_int) e_pc = e_pc + m_code * 4;
        end
      end else begin
        m_priv = m_target; m_active = 0;
      end
    end
    e_write = m_active && m_cleared && (m_cyc == m_clear_cyc);
    e_redir = m_active && m_cleared && (m_cyc == m_clear_cyc + 1);
  endtask

  initial forever begin
    @(posedge CLK);
    model_step();
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge CLK);
    if (m_ready) begin
      chk("intr", {31'd0, intr}, {31'd0, m_active});
      chk("inject_mcause", {31'd0, inject_mcause}, {31'd0, e_write && !m_is_mret});
      chk("inject_mepc", {31'd0, inject_mepc}, {31'd0, e_write && !m_is_mret});
      chk("inject_mtval", {31'd0, inject_mtval}, {31'd0, e_write && !m_is_mret});
      chk("inject_mstatus", {31'd0, inject_mstatus}, {31'd0, e_write});
      chk("insert_pc", {31'd0, insert_pc}, {31'd0, e_redir});
      chk("priv", {30'd0, curr_privilege_level}, {30'd0, m_priv});
      if (e_write) begin
        chk("next_mstatus", next_mstatus, e_mstatus);
        if (!m_is_mret) begin
          chk("next_mcause", next_mcause, e_mcause);
          chk("next_mepc", next_mepc, e_mepc);
          chk("next_mtval", next_mtval, e_mtval);
        end
      end
      if (e_redir) chk("priv_pc", priv_pc, e_pc);
      if (m_rst) begin
        chk("rst_next_mcause", next_mcause, 32'd0);
        chk("rst_next_mstatus", next_mstatus, 32'd0);
        chk("rst_priv_pc", priv_pc, 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic wait_sig(input int which, output bit ok);
    ok = 0;
    for (int k = 0; k < 30 && !ok; k++) begin
      tick();
      case (which)
        0:       ok = inject_mcause;
        1:       ok = inject_mstatus;
        default: ok = insert_pc;
      endcase
    end
    if (!ok) begin
      n_vec++; n_bad++;
      $display("FAIL wait_sig%0d: got timeout, expected strobe within 30 cycles", which);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before 500us");
    $fatal(1);
  end

  initial begin
    bit ok;
    nRST = 0; ex_src = 0; ex_tval = 0; epc = 0; mret = 0; pipe_clear = 1;
    curr_mip = 0; curr_mie = 0; curr_mstatus = 0; curr_mtvec = 0; curr_mepc = 0;
    tick(); tick();
    chk("lit_rst_priv", {30'd0, curr_privilege_level}, 32'h3);
    chk("lit_rst_intr", {31'd0, intr}, 32'h0);
    chk("lit_rst_insert", {31'd0, insert_pc}, 32'h0);
    chk("lit_rst_inject", {31'd0, inject_mcause}, 32'h0);
    nRST = 1;
    tick();

    // Exception 2 with the pipeline stalled for three cycles.
    curr_mtvec = 32'h8000_0000; pipe_clear = 0; epc = 32'h103;
    ex_tval = 32'hDEAD_BEEF; ex_src = 16'h0004;
    tick(); ex_src = 0;
    tick(); tick(); tick();
    pipe_clear = 1;
    wait_sig(0, ok);
    chk("lit_ex2_mcause", next_mcause, 32'h2);
    chk("lit_ex2_mepc", next_mepc, 32'h100);
    chk("lit_ex2_mtval", next_mtval, 32'hDEAD_BEEF);
    chk("lit_ex2_mstatus", next_mstatus, 32'h1800);
    tick();
    chk("lit_ex2_insert", {31'd0, insert_pc}, 32'h1);
    chk("lit_ex2_pc", priv_pc, 32'h8000_0000);
    tick(); tick();

    // Vectored machine timer interrupt.
    curr_mstatus = 32'h8; curr_mip = 32'h80; curr_mie = 32'h80;
    curr_mtvec = 32'h8000_0001; epc = 32'h300;
    wait_sig(0, ok);
    chk("lit_i7_mcause", next_mcause, 32'h8000_0007);
    chk("lit_i7_mie", {31'd0, next_mstatus[3]}, 32'h0);
    chk("lit_i7_mpie", {31'd0, next_mstatus[7]}, 32'h1);
    chk("lit_i7_mtval", next_mtval, 32'h0);
    curr_mip = 0; curr_mie = 0;
    tick();
    chk("lit_i7_pc", priv_pc, 32'h8000_001C);
    tick();

    // Exceptions 3 and 2 plus interrupt 11 together: 3 first, 11 later.
    ex_src = 16'h000C; curr_mip = 32'h800; curr_mie = 32'h800;
    epc = 32'h500; ex_tval = 32'h55;
    tick(); ex_src = 0;
    wait_sig(0, ok);
    chk("lit_ex3_mcause", next_mcause, 32'h3);
    tick();
    chk("lit_ex3_pc", priv_pc, 32'h8000_0000);
    wait_sig(0, ok);
    chk("lit_i11_mcause", next_mcause, 32'h8000_000B);
    curr_mip = 0; curr_mie = 0;
    tick();
    chk("lit_i11_pc", priv_pc, 32'h8000_002C);
    tick();

    // mret to U-mode.
    curr_mstatus = 32'h80; curr_mepc = 32'h400; mret = 1;
    tick(); mret = 0;
    wait_sig(2, ok);
    chk("lit_mret1_pc", priv_pc, 32'h400);
    chk("lit_mret1_mstatus", next_mstatus, 32'h88);
    tick();
    chk("lit_mret1_priv", {30'd0, curr_privilege_level}, 32'h0);

    // From U-mode with MIE = 0 the software interrupt is still taken.
    curr_mstatus = 32'h0; curr_mip = 32'h8; curr_mie = 32'h8;
    curr_mtvec = 32'h8000_0000; epc = 32'h604;
    wait_sig(0, ok);
    chk("lit_i3_mcause", next_mcause, 32'h8000_0003);
    chk("lit_i3_mpp", {30'd0, next_mstatus[12:11]}, 32'h0);
    curr_mip = 0; curr_mie = 0;
    wait_sig(2, ok);
    tick();
    chk("lit_i3_priv", {30'd0, curr_privilege_level}, 32'h3);

    // mret with MPP = 2'b10 lands in U-mode.
    curr_mstatus = 32'h1000; mret = 1;
    tick(); mret = 0;
    wait_sig(2, ok);
    tick();
    chk("lit_mpp10_priv", {30'd0, curr_privilege_level}, 32'h0);

    // Exception 8 from U-mode alongside mret: the trap wins.
    curr_mstatus = 32'h0; ex_src = 16'h0100; mret = 1; epc = 32'h700; ex_tval = 32'h0;
    tick(); ex_src = 0; mret = 0;
    wait_sig(0, ok);
    chk("lit_ex8_mcause", next_mcause, 32'h8);
    chk("lit_ex8_mpp", {30'd0, next_mstatus[12:11]}, 32'h0);
    wait_sig(2, ok);
    tick();

    // mret to 0x200.
    curr_mstatus = 32'h80; curr_mepc = 32'h200; mret = 1;
    tick(); mret = 0;
    wait_sig(2, ok);
    chk("lit_mret2_pc", priv_pc, 32'h200);
    chk("lit_mret2_mie", {31'd0, next_mstatus[3]}, 32'h1);
    tick();
    chk("lit_mret2_priv", {30'd0, curr_privilege_level}, 32'h0);

    // An unlisted interrupt bit is ignored, and mtvec MODE 2 acts as direct.
    curr_mstatus = 32'h8; curr_mip = 32'h1; curr_mie = 32'h1;
    tick(); tick(); tick();
    chk("lit_ign_intr", {31'd0, intr}, 32'h0);
    curr_mip = 32'h2; curr_mie = 32'h2; curr_mtvec = 32'h8000_0002;
    wait_sig(0, ok);
    chk("lit_i1_mcause", next_mcause, 32'h8000_0001);
    curr_mip = 0; curr_mie = 0;
    wait_sig(2, ok);
    chk("lit_i1_pc", priv_pc, 32'h8000_0000);
    tick();

    // Drop to U-mode, then reset in the middle of WAIT_TRAP.
    curr_mstatus = 32'h0; curr_mepc = 32'h900; mret = 1;
    tick(); mret = 0;
    wait_sig(2, ok);
    tick();
    pipe_clear = 0; ex_src = 16'h0001;
    tick(); ex_src = 0;
    tick(); tick();
    nRST = 0;
    tick();
    nRST = 1; pipe_clear = 1;
    chk("lit_midrst_intr", {31'd0, intr}, 32'h0);
    chk("lit_midrst_priv", {30'd0, curr_privilege_level}, 32'h3);
    chk("lit_midrst_inject", {31'd0, inject_mcause}, 32'h0);
    tick(); tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
